// File: rtl/issue_ctrl.sv
// Purpose: dual-lane issue control; stalls ID on c.lw load-use hazards and flushes IF/ID on redirects.
// Latency: control outputs are combinational (same cycle); state and counters update on the next edge.
// Backpressure: holds PC and IF/ID (pc_write/ifid_write low) for LOAD_LAT cycles per load-use hazard.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   id_valid, id_rs*_a/b, id_use*   ID-stage bundle sources and their read enables
//   ex_load_b, ex_rd_b              EX lane B load and its destination
//   ex_jump_a, ex_branch_b          EX redirect sources
//   pc_write, ifid_write            pipeline register update enables
//   idex_bubble, if_flush           NOP insertion into ID/EX, squash of IF/ID
//   state                           RUN=00, STALL=01, FLUSH=10
//   stall_cycles, flush_events      saturating performance counters
module issue_ctrl #(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_a,
    input  logic [4:0]  id_rs2_a,
    input  logic        id_use1_a,
    input  logic        id_use2_a,
    input  logic [4:0]  id_rs1_b,
    input  logic [4:0]  id_rs2_b,
    input  logic        id_use1_b,
    input  logic        id_use2_b,
    input  logic        ex_load_b,
    input  logic [4:0]  ex_rd_b,
    input  logic        ex_jump_a,
    input  logic        ex_branch_b,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        if_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_STALL = 2'b01;
    localparam logic [1:0] S_FLUSH = 2'b10;

    // The RUN cycle that detects the hazard is the first bubble, so STALL
    // covers the remaining LOAD_LAT-1 cycles: counter starts at LOAD_LAT-2.
    localparam logic [2:0] STALL_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

    logic [1:0] state_nxt;
    logic [2:0] stall_cnt;
    logic [2:0] stall_cnt_nxt;
    logic       src_hit;
    logic       hazard;
    logic       redirect;

    // Unused sources never match, and x0 is never a real load destination.
    assign src_hit = (id_use1_a && (id_rs1_a == ex_rd_b)) ||
                     (id_use2_a && (id_rs2_a == ex_rd_b)) ||
                     (id_use1_b && (id_rs1_b == ex_rd_b)) ||
                     (id_use2_b && (id_rs2_b == ex_rd_b));
    assign hazard   = ex_load_b && (ex_rd_b != 5'd0) && id_valid && src_hit;
    assign redirect = ex_jump_a || ex_branch_b;

    // State register, stall counter and performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_RUN;
            stall_cnt    <= 3'd0;
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            if (!ifid_write && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if ((state_nxt == S_FLUSH) && (state != S_FLUSH) && (flush_events != 16'hFFFF)) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = S_RUN;
        stall_cnt_nxt = 3'd0;
        case (state)
            S_RUN: begin
                if (redirect) begin
                    state_nxt = S_FLUSH;
                end else if (hazard && (LOAD_LAT > 1)) begin
                    state_nxt     = S_STALL;
                    stall_cnt_nxt = STALL_INIT;
                end
            end
            S_STALL: begin
                if (redirect) begin
                    state_nxt = S_FLUSH;
                end else if (stall_cnt != 3'd0) begin
                    state_nxt     = S_STALL;
                    stall_cnt_nxt = stall_cnt - 3'd1;
                end
            end
            // FLUSH lasts exactly one cycle after the redirect cycle.
            S_FLUSH: state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        if_flush    = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if_flush    = 1'b1;
        end else begin
            case (state)
                S_STALL: begin
                    // A stall in progress keeps bubbling whether or not the
                    // hazard inputs are still present.
                    idex_bubble = 1'b1;
                    if (redirect) begin
                        if_flush = 1'b1;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end
                end
                S_FLUSH: begin
                    idex_bubble = 1'b1;
                    if_flush    = 1'b1;
                end
                default: begin
                    // RUN, and the unreachable encoding 11
                    if (redirect) begin
                        idex_bubble = 1'b1;
                        if_flush    = 1'b1;
                    end else if (hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Purpose: scoreboard bench for issue_ctrl; three instances (LOAD_LAT 1, 3, 4) share one stimulus stream.
// Latency: expectations are pushed when a vector is driven and popped by the monitor on the next falling edge.
// Backpressure: none; one vector per cycle, the monitor consumes each entry in the cycle it was issued.
module tb_issue_ctrl;

    localparam int LAT [3] = '{1, 3, 4};

    localparam logic [5:0] RUN_OK = 6'b110000;
    localparam logic [5:0] HZ     = 6'b001000;
    localparam logic [5:0] ST     = 6'b001001;
    localparam logic [5:0] RD_RUN = 6'b111100;
    localparam logic [5:0] RD_ST  = 6'b111101;
    localparam logic [5:0] FL     = 6'b111110;
    localparam logic [5:0] RST0   = 6'b001100;
    localparam logic [5:0] RST_ST = 6'b001101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1_a, id_rs2_a, id_rs1_b, id_rs2_b;
    logic       id_use1_a, id_use2_a, id_use1_b, id_use2_b;
    logic       ex_load_b;
    logic [4:0] ex_rd_b;
    logic       ex_jump_a, ex_branch_b;

    logic [2:0]  pcw, ifw, bub, flu;
    logic [1:0]  st [3];
    logic [15:0] sc [3];
    logic [15:0] fe [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        issue_ctrl #(.LOAD_LAT(LAT[g])) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .id_valid     (id_valid),
            .id_rs1_a     (id_rs1_a),
            .id_rs2_a     (id_rs2_a),
            .id_use1_a    (id_use1_a),
            .id_use2_a    (id_use2_a),
            .id_rs1_b     (id_rs1_b),
            .id_rs2_b     (id_rs2_b),
            .id_use1_b    (id_use1_b),
            .id_use2_b    (id_use2_b),
            .ex_load_b    (ex_load_b),
            .ex_rd_b      (ex_rd_b),
            .ex_jump_a    (ex_jump_a),
            .ex_branch_b  (ex_branch_b),
            .pc_write     (pcw[g]),
            .ifid_write   (ifw[g]),
            .idex_bubble  (bub[g]),
            .if_flush     (flu[g]),
            .state        (st[g]),
            .stall_cycles (sc[g]),
            .flush_events (fe[g])
        );
    end

    typedef struct packed {
        int               vec;
        logic [2:0][5:0]  ctl;
        logic             chk_cnt;
        logic [2:0][15:0] sc;
        logic [2:0][15:0] fe;
    } exp_t;

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;

    // Monitor: every issued vector is checked against all three instances.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            popped++;
            for (int g = 0; g < 3; g++) begin
                logic [5:0] act;
                act = {pcw[g], ifw[g], bub[g], flu[g], st[g]};
                checks++;
                if (act !== e.ctl[g]) begin
                    failures++;
                    $display("FAIL ctl lat=%0d vec=%0d actual=%b required=%b (pc,ifid,bub,flush,state)",
                             LAT[g], e.vec, act, e.ctl[g]);
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (sc[g] !== e.sc[g]) begin
                        failures++;
                        $display("FAIL stall_cycles lat=%0d vec=%0d actual=%h required=%h",
                                 LAT[g], e.vec, sc[g], e.sc[g]);
                    end
                    checks++;
                    if (fe[g] !== e.fe[g]) begin
                        failures++;
                        $display("FAIL flush_events lat=%0d vec=%0d actual=%h required=%h",
                                 LAT[g], e.vec, fe[g], e.fe[g]);
                    end
                end
            end
        end
    end

    // Unused sources rs2_a / rs1_b are parked on register 5 with use=0 so
    // they would falsely match ex_rd_b=5 if use gating were missing.
    task automatic set_in(input logic ld, input logic [4:0] rd, input logic [4:0] rs1a,
                          input logic u1a, input logic [4:0] rs2b, input logic u2b,
                          input logic jmp, input logic br);
        id_valid    = 1'b1;
        ex_load_b   = ld;
        ex_rd_b     = rd;
        id_rs1_a    = rs1a;
        id_use1_a   = u1a;
        id_rs2_a    = 5'd5;
        id_use2_a   = 1'b0;
        id_rs1_b    = 5'd5;
        id_use1_b   = 1'b0;
        id_rs2_b    = rs2b;
        id_use2_b   = u2b;
        ex_jump_a   = jmp;
        ex_branch_b = br;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic haz_b();
        set_in(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic issue(input exp_t e);
        exp_q.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [5:0] e1, input logic [5:0] e3, input logic [5:0] e4);
        exp_t e;
        e = '0;
        e.vec = pushed;
        e.ctl = {e4, e3, e1};
        issue(e);
    endtask

    task automatic cyc_c(input logic [5:0] e1, input logic [5:0] e3, input logic [5:0] e4,
                         input logic [15:0] s1, input logic [15:0] s3, input logic [15:0] s4,
                         input logic [15:0] f1, input logic [15:0] f3, input logic [15:0] f4);
        exp_t e;
        e = '0;
        e.vec     = pushed;
        e.ctl     = {e4, e3, e1};
        e.chk_cnt = 1'b1;
        e.sc      = {s4, s3, s1};
        e.fe      = {f4, f3, f1};
        issue(e);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        // Reset holds outputs in their safe pattern, counters frozen even with a hazard present
        cyc_c(RST0, RST0, RST0, 0, 0, 0, 0, 0, 0);
        haz_b();
        cyc_c(RST0, RST0, RST0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b1;
        idle();
        cyc_c(RUN_OK, RUN_OK, RUN_OK, 0, 0, 0, 0, 0, 0);
        // Lane B load-use hazard for one cycle
        haz_b();
        cyc(HZ, HZ, HZ);
        idle();
        cyc_c(RUN_OK, ST, ST, 1, 1, 1, 0, 0, 0);
        cyc_c(RUN_OK, ST, ST, 1, 2, 2, 0, 0, 0);
        cyc_c(RUN_OK, RUN_OK, ST, 1, 3, 3, 0, 0, 0);
        cyc_c(RUN_OK, RUN_OK, RUN_OK, 1, 3, 4, 0, 0, 0);
        // x0 destination never stalls; unused source never matches; invalid bundle never stalls
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(RUN_OK, RUN_OK, RUN_OK);
        set_in(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc_c(RUN_OK, RUN_OK, RUN_OK, 1, 3, 4, 0, 0, 0);
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        cyc(RUN_OK, RUN_OK, RUN_OK);
        // Hazard with taken branch: redirect wins, then a redirect in FLUSH is ignored
        set_in(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        cyc(RD_RUN, RD_RUN, RD_RUN);
        set_in(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc_c(FL, FL, FL, 1, 3, 4, 1, 1, 1);
        idle();
        cyc_c(RUN_OK, RUN_OK, RUN_OK, 1, 3, 4, 1, 1, 1);
        // Lane A hazard, then a jump during the second stall cycle
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(HZ, HZ, HZ);
        idle();
        cyc_c(RUN_OK, ST, ST, 2, 4, 5, 1, 1, 1);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc_c(RD_RUN, RD_ST, RD_ST, 2, 5, 6, 1, 1, 1);
        idle();
        cyc_c(FL, FL, FL, 2, 5, 6, 2, 2, 2);
        cyc_c(RUN_OK, RUN_OK, RUN_OK, 2, 5, 6, 2, 2, 2);
        // Reset in the middle of a stall aborts it
        haz_b();
        cyc(HZ, HZ, HZ);
        rst_n = 1'b0;
        idle();
        cyc_c(RST0, RST_ST, RST_ST, 3, 6, 7, 2, 2, 2);
        rst_n = 1'b1;
        cyc_c(RUN_OK, RUN_OK, RUN_OK, 0, 0, 0, 0, 0, 0);
        // Continuous hazard: every cycle is a bubble, so stall_cycles reaches FFFE after 65534 cycles
        haz_b();
        for (int k = 0; k < 65534; k++) begin
            @(posedge clk);
            #1;
        end
        cyc_c(HZ, ST, ST, 16'hFFFE, 16'hFFFE, 16'hFFFE, 0, 0, 0);
        cyc_c(HZ, HZ, ST, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        cyc_c(HZ, ST, HZ, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        rst_n = 1'b0;
        idle();
        cyc_c(RST0, RST_ST, RST_ST, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        rst_n = 1'b1;
        cyc_c(RUN_OK, RUN_OK, RUN_OK, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if ((exp_q.size() != 0) || (popped != pushed)) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d popped required=%0d", popped, pushed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter: LOAD_LAT, default 1, total bubble cycles per load-use hazard (legal 1..4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 id_valid  input  1  ID stage holds a valid two-lane bundle.
REQ-005 id_rs1_a, id_rs2_a  input  5 each  lane A (32-bit lane) source registers; id_use1_a, id_use2_a  input  1 each  source actually read.
REQ-006 id_rs1_b, id_rs2_b  input  5 each  lane B (compressed lane) source registers; id_use1_b, id_use2_b  input  1 each  source actually read.
REQ-007 ex_load_b  input  1  EX lane B holds c.lw; ex_rd_b  input  5  its destination.
REQ-008 ex_jump_a  input  1  EX lane A JALR resolved; ex_branch_b  input  1  EX lane B branch taken.
REQ-009 pc_write  output  1  PC register update enable.
REQ-010 ifid_write  output  1  IF/ID register update enable.
REQ-011 idex_bubble  output  1  insert NOP into ID/EX.
REQ-012 if_flush  output  1  squash IF/ID contents.
REQ-013 state  output  2  current FSM state (RUN=00, STALL=01, FLUSH=10).
REQ-014 stall_cycles, flush_events  output  16 each  saturating performance counters.

Function
REQ-015 hazard = ex_load_b & (ex_rd_b != 0) & id_valid & any used ID source (lane A or B) equal to ex_rd_b; unused sources never match.
REQ-016 redirect = ex_jump_a | ex_branch_b.
REQ-017 Outputs are combinational from state and current inputs (same-cycle response); state and counters are registered.
REQ-018 RUN, no redirect, no hazard: pc_write=1, ifid_write=1, idex_bubble=0, if_flush=0; stay RUN.
REQ-019 RUN, hazard, no redirect: pc_write=0, ifid_write=0, idex_bubble=1, if_flush=0; next STALL if LOAD_LAT>1 (stall counter loaded with LOAD_LAT-2), else RUN.
REQ-020 RUN, redirect (priority over hazard): pc_write=1, ifid_write=1, idex_bubble=1, if_flush=1; next FLUSH.
REQ-021 STALL, no redirect: outputs as REQ-019; counter decrements; next RUN when counter==0, else STALL.
REQ-022 STALL, redirect: outputs as REQ-020; next FLUSH; stall counter cleared.
REQ-023 FLUSH: pc_write=1, ifid_write=1, idex_bubble=1, if_flush=1 regardless of inputs; redirect and hazard ignored; next RUN (flush always exactly 2 cycles).
REQ-024 State 11 unreachable; if entered, behave as RUN outputs and next state RUN.
REQ-025 stall_cycles increments by 1 each cycle with rst_n=1 and ifid_write=0; saturates at 16'hFFFF.
REQ-026 flush_events increments by 1 on each entry into FLUSH; saturates at 16'hFFFF.
REQ-027 Total load-use bubbles per hazard = LOAD_LAT exactly; hazard re-detected after STALL exit starts a fresh sequence.

Reset
REQ-028 rst_n=0 at rising edge: state<=RUN, stall counter<=0, stall_cycles<=0, flush_events<=0.
REQ-029 While rst_n=0: pc_write=0, ifid_write=0, idex_bubble=1, if_flush=1, counters do not increment.
REQ-030 Reset asserted mid-STALL or mid-FLUSH aborts the sequence; first cycle after release is RUN.

Verification
REQ-031 LOAD_LAT=1, ex_load_b=1, ex_rd_b=5, id_rs2_b=5, id_use2_b=1 for one cycle -> one cycle pc_write=0/ifid_write=0/idex_bubble=1, stall_cycles=1, state stays 00.
REQ-032 LOAD_LAT=3, same hazard -> exactly 3 bubble cycles, state 00,01,01 then 00; stall_cycles=3.
REQ-033 ex_rd_b=0 matching id_rs1_a=0, or id_rs1_a=5 with id_use1_a=0 -> no stall, outputs per REQ-018.
REQ-034 Hazard and ex_branch_b=1 same cycle -> if_flush=1 for 2 cycles, pc_write=1, no stall, flush_events=1; redirect in second flush cycle ignored.
REQ-035 LOAD_LAT=4, redirect during STALL cycle 2 -> FLUSH entered next cycle, total stall_cycles=2, flush_events=1.
REQ-036 Force stall_cycles to 16'hFFFE, hold hazard 3 cycles -> counter 16'hFFFF and holds; rst_n=0 one cycle -> all counters 0, state 00.
